// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment column scanner: one digit lit at a time, with a per-digit dwell,
// dead-time between digits, frame-synchronous double-buffered data and per-digit blanking.
module seven_seg_scan_ctrl #(
    parameter int         NUM_DIGITS  = 8,
    parameter int         REFRESH_DIV = 50000,
    parameter int         DEAD_CYCLES = 2,
    parameter bit         ACTIVE_LOW  = 1'b1,
    parameter logic [3:0] BLANK_CODE  = 4'hA,
    localparam int        IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic                    load,
    output logic [3:0]              data_out,
    output logic [NUM_DIGITS-1:0]   display_column,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam int MAX_CNT = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]        SHOW_END  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]        DEAD_END  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [4*NUM_DIGITS-1:0] BLANK_ALL = {NUM_DIGITS{BLANK_CODE}};
    localparam logic [NUM_DIGITS-1:0]   COL_IDLE  = {NUM_DIGITS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t                  state, n_state;
    logic [IDX_W-1:0]        idx, n_idx;
    logic [CNT_W-1:0]        cnt, n_cnt;
    logic [4*NUM_DIGITS-1:0] shadow, pending, next_shadow;
    logic                    pend_vld;
    logic                    wrap_now;
    logic [NUM_DIGITS-1:0]   nz_above;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   col_sel;

    // The wrap cycle is the final cycle of the last slot, whichever phase closes it.
    function automatic logic is_wrap(input state_t s, input logic [IDX_W-1:0] i,
                                     input logic [CNT_W-1:0] c);
        if (i != LAST_IDX)
            return 1'b0;
        if (DEAD_CYCLES == 0)
            return (s == SHOW) && (c == SHOW_END);
        return (s == DEAD) && (c == DEAD_END);
    endfunction

    function automatic logic [IDX_W-1:0] next_slot(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        n_state = state;
        n_idx   = idx;
        n_cnt   = cnt;
        case (state)
            IDLE: begin
                n_state = SHOW;
                n_idx   = '0;
                n_cnt   = '0;
            end
            SHOW: begin
                if (cnt == SHOW_END) begin
                    n_cnt = '0;
                    if (DEAD_CYCLES == 0) begin
                        n_idx = next_slot(idx);
                    end else begin
                        n_state = DEAD;
                    end
                end else begin
                    n_cnt = cnt + 1'b1;
                end
            end
            DEAD: begin
                if (cnt == DEAD_END) begin
                    n_state = SHOW;
                    n_idx   = next_slot(idx);
                    n_cnt   = '0;
                end else begin
                    n_cnt = cnt + 1'b1;
                end
            end
            default: begin
                n_state = IDLE;
                n_idx   = '0;
                n_cnt   = '0;
            end
        endcase
    end

    // Shadow swaps only at the frame boundary; a load on that very cycle bypasses pending.
    always_comb begin
        wrap_now    = is_wrap(state, idx, cnt);
        next_shadow = shadow;
        if (wrap_now && load)
            next_shadow = digit_data;
        else if (wrap_now && pend_vld)
            next_shadow = pending;
    end

    // nz_above[j]: some nibble at position j or higher is non-zero.
    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            acc         = acc | (next_shadow[4*j +: 4] != 4'd0);
            nz_above[j] = acc;
        end
    end

    always_comb begin
        col_sel = NUM_DIGITS'(1) << n_idx;
        lit     = (n_state == SHOW) && digit_en[n_idx] &&
                  !(lz_suppress && (n_idx != '0) && !nz_above[n_idx]);
    end

    // Output stage: outputs are registered from the next-state view of the scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            frame_done     <= 1'b0;
            display_column <= COL_IDLE;
            data_out       <= BLANK_CODE;
            shadow         <= BLANK_ALL;
            pending        <= BLANK_ALL;
            pend_vld       <= 1'b0;
        end else begin
            state          <= n_state;
            idx            <= n_idx;
            cnt            <= n_cnt;
            frame_done     <= is_wrap(n_state, n_idx, n_cnt);
            display_column <= lit ? (col_sel ^ COL_IDLE) : COL_IDLE;
            data_out       <= lit ? next_shadow[{n_idx, 2'b00} +: 4] : BLANK_CODE;
            shadow         <= next_shadow;
            if (wrap_now) begin
                pend_vld <= 1'b0;
            end else if (load) begin
                pending  <= digit_data;
                pend_vld <= 1'b1;
            end
        end
    end

    assign digit_idx = idx;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (4 digits, dwell 4, dead 1): directed scenarios then random
// traffic, all checked cycle by cycle against a time-position reference model.
module tb_seven_seg_scan_ctrl;

    localparam int ND     = 4;
    localparam int RD     = 4;
    localparam int DC     = 1;
    localparam int SLOT   = RD + DC;
    localparam int FRAME  = SLOT * ND;
    localparam logic [3:0] BLANK = 4'hA;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digit_data;
    logic [3:0]  digit_en;
    logic        lz_suppress;
    logic        load;
    logic [3:0]  data_out;
    logic [3:0]  display_column;
    logic [1:0]  digit_idx;
    logic        frame_done;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC),
        .ACTIVE_LOW (1'b1),
        .BLANK_CODE (BLANK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .digit_data    (digit_data),
        .digit_en      (digit_en),
        .lz_suppress   (lz_suppress),
        .load          (load),
        .data_out      (data_out),
        .display_column(display_column),
        .digit_idx     (digit_idx),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: scan position counted in cycles since the first SHOW cycle.
    bit          started;
    int          pos;
    logic [15:0] m_shadow, m_pend;
    bit          m_flag;
    logic [3:0]  exp_col, exp_data;
    logic [1:0]  exp_idx;
    logic        exp_fd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit wrap;
        int slot;
        bit show, sup, lit;
        if (reset) begin
            started  = 1'b0;
            pos      = 0;
            m_shadow = 16'hAAAA;
            m_pend   = 16'hAAAA;
            m_flag   = 1'b0;
            exp_col  = 4'hF;
            exp_data = BLANK;
            exp_idx  = 2'd0;
            exp_fd   = 1'b0;
        end else begin
            wrap = started && (pos % FRAME == FRAME - 1);
            if (started) pos++;
            else begin
                started = 1'b1;
                pos     = 0;
            end
            if (wrap) begin
                if (load) m_shadow = digit_data;
                else if (m_flag) m_shadow = m_pend;
                m_flag = 1'b0;
            end else if (load) begin
                m_pend = digit_data;
                m_flag = 1'b1;
            end
            slot     = (pos / SLOT) % ND;
            show     = (pos % SLOT) < RD;
            sup      = lz_suppress && (slot != 0) && ((m_shadow >> (4 * slot)) == 16'd0);
            lit      = show && digit_en[slot] && !sup;
            exp_col  = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_data = lit ? 4'((m_shadow >> (4 * slot)) & 16'hF) : BLANK;
            exp_idx  = 2'(slot);
            exp_fd   = (pos % FRAME == FRAME - 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("column", display_column, exp_col);
        chk("data_out", data_out, exp_data);
        chk("digit_idx", digit_idx, exp_idx);
        chk("frame_done", frame_done, exp_fd);
        load = 1'b0;
    endtask

    task automatic run_to(input int target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (started && (pos % FRAME == target)) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("sync_timeout", hit, 1'b1);
    endtask

    initial begin
        logic [15:0] v;
        int          nz;
        reset       = 1'b1;
        load        = 1'b0;
        digit_data  = 16'h0;
        digit_en    = 4'hF;
        lz_suppress = 1'b0;
        started     = 1'b0;
        pos         = 0;

        repeat (3) step();
        reset = 1'b0;
        step();

        digit_data = 16'h4321; load = 1'b1;
        repeat (45) step();

        run_to(6);
        digit_data = 16'h9876; load = 1'b1;
        repeat (40) step();

        lz_suppress = 1'b1;
        digit_data = 16'h0040; load = 1'b1;
        repeat (40) step();
        digit_data = 16'h0000; load = 1'b1;
        repeat (40) step();
        lz_suppress = 1'b0;

        digit_en = 4'b0101;
        digit_data = 16'h4321; load = 1'b1;
        repeat (40) step();
        digit_en = 4'hF;

        run_to(0);
        digit_data = 16'h5555; load = 1'b1;
        step();
        run_to(11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (25) step();

        run_to(FRAME - 1);
        digit_data = 16'h7777; load = 1'b1;
        repeat (25) step();

        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                v  = 16'($urandom);
                nz = $urandom_range(0, 4);
                digit_data = (nz == 4) ? 16'h0 : (v & (16'hFFFF >> (4 * nz)));
                load = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 39) == 0) lz_suppress = ~lz_suppress;
            reset = ($urandom_range(0, 249) == 0);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
